z3_slave_engine: RTL and testbench

- Parametrised Zorro III slave cycle controller. Replaces the fixed 4-state slave FSM and hard-coded region decode with a configurable N-region target, run entirely in the CLK_50M domain.
- Synchronises FCS_n and latches address and direction. Decodes one of NUM_REGIONS address windows relative to the autoconfigured base.
- Sequences each region via a select/ack handshake or a fixed wait-state count, then drives DTACK.
- Adds a bus-hang timeout and clean abort on early FCS_n negation, which the previous controller lacked.

---
 rtl/z3_slave_engine.sv | 209 ++++++++++++++++++++
 tb/tb_z3_slave_engine.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z3_slave_engine.sv
// -----------------------------------------------------------------------------
// z3_slave_engine
// Zorro III slave cycle controller with NUM_REGIONS decoded target windows.
// The FCS_n/DS_n strobes are brought into CLK_50M through two-flop
// synchronisers. A full cycle is claimed when the address falls inside the
// autoconfigured 16 MB space and one of the region windows matches. Each
// region then terminates either on its region_ack level or after a fixed
// wait-state count. A bus-hang timeout forces termination. FCS_n negating
// early aborts the cycle cleanly.
//
// Ports
//   CLK_50M, IORST_n      : clock, asynchronous active-low reset
//   FCS_n, READ, DS_n, FC : Zorro cycle strobes/qualifiers (strobes async)
//   A                     : Zorro address bus
//   configured, base_addr : autoconfig state and assigned A[31:24]
//   master_active         : local DMA owns the bus, decode inhibited
//   region_ack            : per-region completion level, sampled in DATA
//   region_sel            : one-hot region select for the whole cycle
//   cycle_read, addr_lat  : latched READ and A[23:0]
//   slave_n, dtack        : Zorro SLAVE_n, DTACK drive request
//   timeout_err           : one-cycle pulse on forced termination
//   state                 : FSM state (debug)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module z3_slave_engine #(
    parameter int                        NUM_REGIONS = 4,
    parameter logic [24*NUM_REGIONS-1:0] REGION_BASE = {24'h8C0000, 24'h880000, 24'h800000, 24'h000000},
    parameter logic [24*NUM_REGIONS-1:0] REGION_MASK = {24'hFC0000, 24'hFC0000, 24'hF80000, 24'h800000},
    parameter logic [4*NUM_REGIONS-1:0]  REGION_WS   = {4'd0, 4'd0, 4'd0, 4'd3},
    parameter int                        TIMEOUT_CYC = 255
) (
    input  logic                   CLK_50M,
    input  logic                   IORST_n,
    input  logic                   FCS_n,
    input  logic                   READ,
    input  logic [3:0]             DS_n,
    input  logic [2:0]             FC,
    input  logic [31:0]            A,
    input  logic                   configured,
    input  logic [7:0]             base_addr,
    input  logic                   master_active,
    input  logic [NUM_REGIONS-1:0] region_ack,
    output logic [NUM_REGIONS-1:0] region_sel,
    output logic                   cycle_read,
    output logic [23:0]            addr_lat,
    output logic                   slave_n,
    output logic                   dtack,
    output logic                   timeout_err,
    output logic [2:0]             state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_ACK   = 3'd3,
        S_TERM  = 3'd4
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_fcs_meta, r_fcs_s;
    logic [3:0]             r_ds_meta, r_ds_s;
    logic [23:0]            r_addr_lat;
    logic                   r_cycle_read;
    logic [NUM_REGIONS-1:0] r_sel;
    logic [3:0]             r_ws_cnt;
    logic [7:0]             r_to_cnt;

    logic [NUM_REGIONS-1:0] w_win_hit;
    logic [NUM_REGIONS-1:0] w_sel_onehot;
    logic                   w_any_win;
    logic                   w_bus_ok;
    logic                   w_hit;
    logic [3:0]             w_ws_sel;
    logic                   w_ws_done;
    logic                   w_ack_done;
    logic                   w_timeout;
    logic                   w_timeout_pulse;
    logic                   w_in_cycle;
    logic                   w_unused;

    // FC[2] only distinguishes supervisor/user and plays no part in decode.
    assign w_unused = FC[2];

    // ---------------------------------------------------------------- sync
    always_ff @(posedge CLK_50M or negedge IORST_n) begin
        if (!IORST_n) begin
            r_fcs_meta <= 1'b1;
            r_fcs_s    <= 1'b1;
            r_ds_meta  <= 4'hF;
            r_ds_s     <= 4'hF;
        end else begin
            r_fcs_meta <= FCS_n;
            r_fcs_s    <= r_fcs_meta;
            r_ds_meta  <= DS_n;
            r_ds_s     <= r_ds_meta;
        end
    end

    // -------------------------------------------------------------- decode
    for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_win
        assign w_win_hit[gi] = ((A[23:0] & REGION_MASK[24*gi +: 24]) == REGION_BASE[24*gi +: 24]);
    end

    // Overlapping windows resolve to the lowest index.
    always_comb begin
        w_sel_onehot = '0;
        w_any_win    = 1'b0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (w_win_hit[i] && !w_any_win) begin
                w_sel_onehot[i] = 1'b1;
                w_any_win       = 1'b1;
            end
        end
    end

    // FC[1]^FC[0] accepts user/supervisor data and program spaces only.
    assign w_bus_ok = configured && !master_active && (A[31:24] == base_addr) && (FC[1] ^ FC[0]);
    assign w_hit    = w_bus_ok && w_any_win;

    // Wait-state count and ack of the latched region.
    always_comb begin
        w_ws_sel = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (r_sel[i]) w_ws_sel = w_ws_sel | REGION_WS[4*i +: 4];
        end
    end

    assign w_ws_done  = (w_ws_sel != 4'd0) && (r_ws_cnt == (w_ws_sel - 4'd1));
    assign w_ack_done = (w_ws_sel == 4'd0) && (|(region_ack & r_sel));
    assign w_timeout  = (r_to_cnt == TO_LAST);

    // ----------------------------------------------------------------- FSM
    always_ff @(posedge CLK_50M or negedge IORST_n) begin
        if (!IORST_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next    = r_state;
        w_timeout_pulse = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_fcs_s && w_hit) w_state_next = S_START;
            end
            S_START: begin
                if (r_fcs_s)                             w_state_next = S_IDLE;
                else if (r_cycle_read || (r_ds_s != 4'hF)) w_state_next = S_DATA;
            end
            S_DATA: begin
                // Early FCS_n negation takes priority over any completion.
                if (r_fcs_s) begin
                    w_state_next = S_IDLE;
                end else if (w_ws_done || w_ack_done || w_timeout) begin
                    w_state_next    = S_ACK;
                    w_timeout_pulse = w_timeout;
                end
            end
            S_ACK: begin
                if (r_fcs_s) w_state_next = S_TERM;
            end
            S_TERM:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge CLK_50M or negedge IORST_n) begin
        if (!IORST_n) begin
            r_addr_lat   <= '0;
            r_cycle_read <= 1'b0;
            r_sel        <= '0;
        end else if (r_state == S_IDLE && !r_fcs_s && w_hit) begin
            r_addr_lat   <= A[23:0];
            r_cycle_read <= READ;
            r_sel        <= w_sel_onehot;
        end
    end

    // Counters run only while in DATA, so they are zero on DATA entry.
    always_ff @(posedge CLK_50M or negedge IORST_n) begin
        if (!IORST_n) begin
            r_ws_cnt <= '0;
            r_to_cnt <= '0;
        end else if (r_state != S_DATA) begin
            r_ws_cnt <= '0;
            r_to_cnt <= '0;
        end else begin
            r_ws_cnt <= r_ws_cnt + 4'd1;
            if (r_to_cnt != 8'hFF) r_to_cnt <= r_to_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------- outputs
    // Outputs decode straight from the state register so an asynchronous
    // reset releases DTACK and the selects without waiting for a clock.
    assign w_in_cycle  = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_ACK);
    assign region_sel  = w_in_cycle ? r_sel : '0;
    assign slave_n     = !w_in_cycle;
    assign dtack       = (r_state == S_ACK);
    assign timeout_err = w_timeout_pulse;
    assign cycle_read  = r_cycle_read;
    assign addr_lat    = r_addr_lat;
    assign state       = r_state;

endmodule

// File: tb/tb_z3_slave_engine.sv
`timescale 1ns/1ps
module tb_z3_slave_engine;

    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fcs_n;
    logic          read;
    logic [3:0]    ds_n;
    logic [2:0]    fc;
    logic [31:0]   a;
    logic          configured;
    logic [7:0]    base_addr;
    logic          master_active;
    logic [NR-1:0] region_ack;
    logic [NR-1:0] region_sel;
    logic          cycle_read;
    logic [23:0]   addr_lat;
    logic          slave_n;
    logic          dtack;
    logic          timeout_err;
    logic [2:0]    state;

    z3_slave_engine dut (
        .CLK_50M       (clk),
        .IORST_n       (rst_n),
        .FCS_n         (fcs_n),
        .READ          (read),
        .DS_n          (ds_n),
        .FC            (fc),
        .A             (a),
        .configured    (configured),
        .base_addr     (base_addr),
        .master_active (master_active),
        .region_ack    (region_ack),
        .region_sel    (region_sel),
        .cycle_read    (cycle_read),
        .addr_lat      (addr_lat),
        .slave_n       (slave_n),
        .dtack         (dtack),
        .timeout_err   (timeout_err),
        .state         (state)
    );

    always #10 clk = ~clk;

    // Expected transaction record.
    typedef struct {
        int          id;
        logic [3:0]  sel;
        logic        rd;
        logic [23:0] addr;
        int          lat;     // DATA cycles until dtack (0 = no dtack expected)
        int          to_cyc;  // DATA cycle of the timeout pulse, 0 = none
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   txn_id   = 0;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_START = 3'd1, ST_DATA = 3'd2,
                           ST_ACK  = 3'd3, ST_TERM  = 3'd4;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_defaults;
        fcs_n         = 1'b1;
        read          = 1'b1;
        ds_n          = 4'hF;
        fc            = 3'b001;
        a             = 32'h0;
        configured    = 1'b1;
        base_addr     = 8'hE9;
        master_active = 1'b0;
        region_ack    = '0;
    endtask

    // Full claimed access: start, wait for dtack, compare against the
    // scoreboard entry pushed here, then finish the cycle with FCS_n high.
    task automatic do_access(input logic [31:0] addr, input logic rd, input int ack_cyc,
                             input int ds_hold, input logic [3:0] exp_sel,
                             input int exp_lat, input int exp_to);
        exp_t e;
        exp_t got;
        int   ndata;
        int   to_seen;
        int   to_at;
        int   budget;
        bit   seen_dtack;
        e.id = txn_id; e.sel = exp_sel; e.rd = rd; e.addr = addr[23:0];
        e.lat = exp_lat; e.to_cyc = exp_to;
        sb.push_back(e);
        txn_id++;

        a = addr; read = rd; fc = 3'b001; region_ack = '0;
        ds_n  = rd ? 4'h0 : 4'hF;
        fcs_n = 1'b0;
        tick; tick;
        check_eq("slave_n_before_sync", 32'(slave_n), 32'd1);
        tick;
        check_eq("slave_n_claim", 32'(slave_n), 32'd0);
        check_eq("sel_claim", 32'(region_sel), 32'(exp_sel));
        check_eq("state_start", 32'(state), 32'(ST_START));
        if (!rd) begin
            for (int i = 0; i < ds_hold; i++) tick;
            check_eq("state_ds_held", 32'(state), 32'(ST_START));
            ds_n = 4'h0;
            tick; tick;
            check_eq("state_ds_sync", 32'(state), 32'(ST_START));
        end
        tick;
        check_eq("state_data_entry", 32'(state), 32'(ST_DATA));

        ndata = 0; to_seen = 0; to_at = 0; budget = 400; seen_dtack = 0;
        while (budget > 0) begin
            if (dtack) begin
                seen_dtack = 1;
                break;
            end
            if (state == ST_DATA) ndata++;
            if (timeout_err) begin
                to_seen++;
                to_at = ndata;
            end
            region_ack = (ndata == ack_cyc) ? exp_sel : 4'h0;
            tick;
            budget--;
        end
        check_eq("dtack_within_budget", 32'(seen_dtack), 32'd1);

        got = sb.pop_front();
        check_eq("lat", 32'(ndata), 32'(got.lat));
        check_eq("sel_data", 32'(region_sel), 32'(got.sel));
        check_eq("cycle_read", 32'(cycle_read), 32'(got.rd));
        check_eq("addr_lat", 32'(addr_lat), 32'(got.addr));

        region_ack = '0;
        tick;
        if (timeout_err) to_seen++;
        check_eq("timeout_count", 32'(to_seen), (got.to_cyc != 0) ? 32'd1 : 32'd0);
        check_eq("timeout_at", 32'(to_at), 32'(got.to_cyc));
        check_eq("dtack_hold_ack_low", 32'(dtack), 32'd1);

        fcs_n = 1'b1;
        tick; tick;
        check_eq("dtack_until_sync", 32'(dtack), 32'd1);
        tick;
        check_eq("state_term", 32'(state), 32'(ST_TERM));
        check_eq("dtack_term", 32'(dtack), 32'd0);
        check_eq("slave_n_term", 32'(slave_n), 32'd1);
        check_eq("sel_term", 32'(region_sel), 32'd0);
        tick;
        check_eq("state_idle_after", 32'(state), 32'(ST_IDLE));
        $display("txn %0d: addr=%h rd=%0d sel=%b lat=%0d timeout_at=%0d",
                 got.id, addr, rd, got.sel, ndata, to_at);
        ds_n = 4'hF;
    endtask

    // A cycle that must not be claimed; region_ack held high to tempt it.
    task automatic no_hit(input string tag);
        exp_t e;
        exp_t got;
        bit   active;
        e.id = txn_id; e.sel = 4'h0; e.rd = 1'b1; e.addr = a[23:0]; e.lat = 0; e.to_cyc = 0;
        sb.push_back(e);
        txn_id++;
        active = 0;
        read = 1'b1; ds_n = 4'h0; region_ack = '1;
        fcs_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (!slave_n || region_sel != 0 || dtack || state != ST_IDLE) active = 1;
        end
        got = sb.pop_front();
        check_eq(tag, 32'(active), 32'(got.sel != 0));
        $display("txn %0d: ignored cycle %s addr=%h active=%0d", got.id, tag, a, active);
        fcs_n = 1'b1; region_ack = '0; ds_n = 4'hF;
        tick; tick; tick;
        set_defaults();
    endtask

    initial begin
        bit seen;
        set_defaults();
        rst_n = 1'b0;
        #5;
        check_eq("rst_state", 32'(state), 32'(ST_IDLE));
        check_eq("rst_sel", 32'(region_sel), 32'd0);
        check_eq("rst_dtack", 32'(dtack), 32'd0);
        check_eq("rst_slave_n", 32'(slave_n), 32'd1);
        check_eq("rst_timeout", 32'(timeout_err), 32'd0);
        check_eq("rst_addr", 32'(addr_lat), 32'd0);
        check_eq("rst_read", 32'(cycle_read), 32'd0);
        tick; tick;
        rst_n = 1'b1;
        tick; tick;

        // Region 1 read, ack raised in DATA cycle 5.
        do_access(32'hE980_0004, 1'b1, 5, 0, 4'b0010, 5, 0);
        // Region 0, three wait states; an early ack must be ignored.
        do_access(32'hE900_0010, 1'b1, 1, 0, 4'b0001, 3, 0);
        // Region 2 write, data strobes held off for 10 cycles.
        do_access(32'hE988_0020, 1'b0, 2, 10, 4'b0100, 2, 0);
        // Region 3, no ack ever: forced termination.
        do_access(32'hE98C_0000, 1'b1, 0, 0, 4'b1000, 255, 255);

        // Unclaimed cycles.
        a = 32'hE980_0004; master_active = 1'b1; no_hit("ignore_master_active");
        a = 32'hE980_0004; configured = 1'b0;    no_hit("ignore_unconfigured");
        a = 32'hE880_0004;                       no_hit("ignore_base_mismatch");
        a = 32'hE980_0004; fc = 3'b111;          no_hit("ignore_fc_cpu_space");

        // Abort in DATA, with an ack arriving the same cycle FCS_n is seen high.
        a = 32'hE980_0004; read = 1'b1; ds_n = 4'h0; fcs_n = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) tick;
        check_eq("abort_in_data", 32'(state), 32'(ST_DATA));
        tick; tick;
        fcs_n = 1'b1;
        tick;
        if (dtack) seen = 1;
        tick;
        if (dtack) seen = 1;
        check_eq("abort_still_data", 32'(state), 32'(ST_DATA));
        region_ack = 4'b0010;
        tick;
        if (dtack) seen = 1;
        check_eq("abort_state_idle", 32'(state), 32'(ST_IDLE));
        tick;
        if (dtack) seen = 1;
        check_eq("abort_no_dtack", 32'(seen), 32'd0);
        $display("txn %0d: abort in DATA, state=%0d dtack_seen=%0d", txn_id, state, seen);
        txn_id++;
        set_defaults();
        tick; tick;

        // Asynchronous reset while in ACK.
        a = 32'hE980_0004; read = 1'b1; ds_n = 4'h0; fcs_n = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        region_ack = 4'b0010;
        tick;
        check_eq("rstack_dtack_set", 32'(dtack), 32'd1);
        #3 rst_n = 1'b0;
        #2;
        check_eq("rstack_dtack", 32'(dtack), 32'd0);
        check_eq("rstack_sel", 32'(region_sel), 32'd0);
        check_eq("rstack_state", 32'(state), 32'(ST_IDLE));
        check_eq("rstack_slave_n", 32'(slave_n), 32'd1);
        check_eq("rstack_addr", 32'(addr_lat), 32'd0);
        $display("txn %0d: reset during ACK, dtack=%0d state=%0d", txn_id, dtack, state);
        txn_id++;
        set_defaults();
        tick; tick;
        rst_n = 1'b1;
        tick; tick;

        // Clean access after the reset still works.
        do_access(32'hE980_0100, 1'b1, 1, 0, 4'b0010, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
